// File: rtl/pipe_loader.sv
// Host program/debug controller: loads and reads back pipeline memories and registers,
// pulses core reset, and runs the core for N cycles. Optional breakpoint: PIPE_LOADER_BREAK_EN.
module pipe_loader #(
   parameter int RD_LAT  = 1,
   parameter int RST_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [8:0]  cmd_addr,
   input  logic [63:0] cmd_data,
   input  logic        halt,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic [3:0]  rsp_flags,
   output logic        err,
   output logic        pipe_en,
   output logic        core_reset,
   output logic        imem_we,
   output logic        imem_re,
   output logic        dmem_we,
   output logic        dmem_re,
   output logic        reg_re,
   output logic [8:0]  imem_addr,
   output logic [31:0] imem_data,
   output logic [7:0]  dmem_addr,
   output logic [63:0] dmem_data,
   output logic [3:0]  reg_addr,
   input  logic [31:0] imem_out,
   input  logic [63:0] dmem_out,
   input  logic [63:0] reg_out,
   input  logic        N,
   input  logic        Z,
   input  logic        C,
   input  logic        V,
   input  logic [8:0]  PC
);
   localparam logic [2:0] OP_WR_IMEM  = 3'd0;
   localparam logic [2:0] OP_WR_DMEM  = 3'd1;
   localparam logic [2:0] OP_RUN      = 3'd2;
   localparam logic [2:0] OP_RD_IMEM  = 3'd3;
   localparam logic [2:0] OP_RD_DMEM  = 3'd4;
   localparam logic [2:0] OP_RD_REG   = 3'd5;
   localparam logic [2:0] OP_CORE_RST = 3'd6;
   localparam int         CNT_W       = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_RUN   = 3'd3,
      S_CRST  = 3'd4,
      S_RSP   = 3'd5
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_op, w_op;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [15:0]        r_len, r_exec, w_exec_nxt, w_exec_inc;
   logic               r_boot, r_cmd_ready, r_rsp_valid, r_err, r_core_reset;
   logic               r_imem_we, r_imem_re, r_dmem_we, r_dmem_re, r_reg_re;
   logic [8:0]         r_imem_addr;
   logic [31:0]        r_imem_data;
   logic [7:0]         r_dmem_addr;
   logic [63:0]        r_dmem_data;
   logic [3:0]         r_reg_addr;
   logic [63:0]        r_rsp_data, w_rsp_word;
   logic [3:0]         r_rsp_flags;
   logic               w_accept, w_rsp_load, w_err_set, w_bp_hit, w_stop;

   function automatic logic [63:0] run_word(input logic [8:0] pc, input logic [15:0] cyc,
                                            input logic halted, input logic bp);
      return {30'd0, bp, halted, cyc, 7'd0, pc};
   endfunction

   assign w_accept = cmd_valid & r_cmd_ready;
   assign w_op     = w_accept ? cmd_op : r_op;

`ifdef PIPE_LOADER_BREAK_EN
   logic [8:0] r_bp_addr;
   logic       r_bp_en;

   // Breakpoint target latched with each RUN command
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bp_addr <= 9'd0;
         r_bp_en   <= 1'b0;
      end else if (w_accept && cmd_op == OP_RUN) begin
         r_bp_addr <= cmd_addr;
         r_bp_en   <= cmd_data[16];
      end
   end

   // Checked against the PC before the cycle would execute
   assign w_bp_hit = (r_state == S_RUN) && r_bp_en && (PC == r_bp_addr);
`else
   assign w_bp_hit = 1'b0;
`endif

   assign w_stop  = halt | w_bp_hit;
   assign pipe_en = (r_state == S_RUN) && !w_stop;

   // Next-state and response-capture decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_exec_nxt  = r_exec;
      w_exec_inc  = r_exec + 16'd1;
      w_rsp_load  = 1'b0;
      w_rsp_word  = 64'd0;
      w_err_set   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cnt_nxt  = {CNT_W{1'b0}};
               w_exec_nxt = 16'd0;
               case (cmd_op)
                  OP_WR_IMEM, OP_WR_DMEM:           w_state_nxt = S_WRITE;
                  OP_RD_IMEM, OP_RD_DMEM, OP_RD_REG: w_state_nxt = S_READ;
                  OP_RUN: begin
                     if (cmd_data[15:0] == 16'd0) begin
                        w_state_nxt = S_RSP;
                        w_rsp_load  = 1'b1;
                        w_rsp_word  = run_word(PC, 16'd0, 1'b0, 1'b0);
                     end else begin
                        w_state_nxt = S_RUN;
                     end
                  end
                  OP_CORE_RST:                       w_state_nxt = S_CRST;
                  default:                           w_err_set   = 1'b1;
               endcase
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WRITE: w_state_nxt = S_IDLE;
         S_READ: begin
            if (r_cnt == CNT_W'(RD_LAT)) begin
               w_state_nxt = S_RSP;
               w_rsp_load  = 1'b1;
               case (r_op)
                  OP_RD_IMEM: w_rsp_word = {32'd0, imem_out};
                  OP_RD_DMEM: w_rsp_word = dmem_out;
                  default:    w_rsp_word = reg_out;
               endcase
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (w_stop) begin
               w_state_nxt = S_RSP;
               w_rsp_load  = 1'b1;
               w_rsp_word  = run_word(PC, r_exec, halt, w_bp_hit);
            end else begin
               w_exec_nxt = w_exec_inc;
               if (w_exec_inc == r_len) begin
                  w_state_nxt = S_RSP;
                  w_rsp_load  = 1'b1;
                  w_rsp_word  = run_word(PC, w_exec_inc, 1'b0, 1'b0);
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_CRST: begin
            if (r_cnt == CNT_W'(RST_CYC - 1)) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RSP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, counters and registered pipeline controls
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_op         <= 3'd0;
         r_cnt        <= {CNT_W{1'b0}};
         r_len        <= 16'd0;
         r_exec       <= 16'd0;
         r_boot       <= 1'b1;
         r_cmd_ready  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_core_reset <= 1'b1;
         r_err        <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_re    <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_re    <= 1'b0;
         r_reg_re     <= 1'b0;
         r_rsp_data   <= 64'd0;
         r_rsp_flags  <= 4'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_exec       <= w_exec_nxt;
         r_boot       <= 1'b0;
         r_cmd_ready  <= (w_state_nxt == S_IDLE);
         r_rsp_valid  <= (w_state_nxt == S_RSP);
         // Core reset also stretches one cycle past the block's own reset
         r_core_reset <= r_boot | (w_state_nxt == S_CRST);
         r_err        <= r_err | w_err_set;
         r_imem_we    <= (w_state_nxt == S_WRITE) && (w_op == OP_WR_IMEM);
         r_dmem_we    <= (w_state_nxt == S_WRITE) && (w_op == OP_WR_DMEM);
         r_imem_re    <= (w_state_nxt == S_READ) && (w_op == OP_RD_IMEM);
         r_dmem_re    <= (w_state_nxt == S_READ) && (w_op == OP_RD_DMEM);
         r_reg_re     <= (w_state_nxt == S_READ) && (w_op == OP_RD_REG);
         if (w_accept) r_op <= cmd_op;
         if (w_accept && cmd_op == OP_RUN) r_len <= cmd_data[15:0];
         if (w_rsp_load) begin
            r_rsp_data  <= w_rsp_word;
            r_rsp_flags <= {N, Z, C, V};
         end
      end
   end

   // Address/data ports update only when a command targets them
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_imem_addr <= 9'd0;
         r_imem_data <= 32'd0;
         r_dmem_addr <= 8'd0;
         r_dmem_data <= 64'd0;
         r_reg_addr  <= 4'd0;
      end else if (w_accept) begin
         if (cmd_op == OP_WR_IMEM || cmd_op == OP_RD_IMEM) r_imem_addr <= cmd_addr;
         if (cmd_op == OP_WR_IMEM) r_imem_data <= cmd_data[31:0];
         if (cmd_op == OP_WR_DMEM || cmd_op == OP_RD_DMEM) r_dmem_addr <= cmd_addr[7:0];
         if (cmd_op == OP_WR_DMEM) r_dmem_data <= cmd_data;
         if (cmd_op == OP_RD_REG) r_reg_addr <= cmd_addr[3:0];
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_flags  = r_rsp_flags;
   assign err        = r_err;
   assign core_reset = r_core_reset;
   assign imem_we    = r_imem_we;
   assign imem_re    = r_imem_re;
   assign dmem_we    = r_dmem_we;
   assign dmem_re    = r_dmem_re;
   assign reg_re     = r_reg_re;
   assign imem_addr  = r_imem_addr;
   assign imem_data  = r_imem_data;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_data  = r_dmem_data;
   assign reg_addr   = r_reg_addr;
endmodule
